// File: rtl/wb_port_scheduler_pkg.sv
// Shared write-back definitions: mux select encoding, scheduler states and
// the default register address width.
package wb_port_scheduler_pkg;

    localparam int WB_AW = 4;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;
    localparam logic [1:0] WB_SEL_MDU  = 2'd3;

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_MDU_HI = 1'b1;

endpackage

// File: rtl/wb_port_scheduler_rr_arbiter4.sv
// Four-way combinational arbiter: round-robin from a pointer, or fixed
// lowest-index-first priority when RR_EN is 0.
module rr_arbiter4 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [3:0] i_elig,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_win,
    output logic [1:0] o_idx,
    output logic       o_any,
    output logic [1:0] o_ptr_nxt
);

    logic [1:0] w_base;
    logic [1:0] w_cand;
    logic [3:0] w_win;
    logic [1:0] w_idx;
    logic       w_any;

    assign w_base = RR_EN ? i_ptr : 2'd0;

    // Search upward from the base, wrapping mod 4; first eligible bit wins.
    always_comb begin
        w_win  = '0;
        w_any  = 1'b0;
        w_idx  = w_base;
        w_cand = w_base;
        for (int k = 0; k < 4; k++) begin
            w_cand = w_base + 2'(k);
            if (!w_any && i_elig[w_cand]) begin
                w_win[w_cand] = 1'b1;
                w_any         = 1'b1;
                w_idx         = w_cand;
            end
        end
    end

    assign o_win     = w_win;
    assign o_idx     = w_idx;
    assign o_any     = w_any;
    assign o_ptr_nxt = w_idx + 2'd1;

endmodule

// File: rtl/wb_port_scheduler.sv
// Register-file write-port scheduler: arbitrates four write-back sources and
// issues MDU results as an atomic low-then-high pair of 16-bit writes.
module wb_port_scheduler
    import wb_port_scheduler_pkg::*;
#(
    parameter int              AW      = WB_AW,
    parameter bit              RR_EN   = 1'b1,
    parameter logic [AW-1:0]   HI_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    i_req,
    input  logic [AW-1:0] i_dst0,
    input  logic [AW-1:0] i_dst1,
    input  logic [AW-1:0] i_dst2,
    input  logic [AW-1:0] i_dst3,
    input  logic          i_stall,
    output logic [3:0]    o_gnt,
    output logic [1:0]    o_sel,
    output logic          o_rf_we,
    output logic [AW-1:0] o_rf_waddr,
    output logic          o_mdu_hi,
    output logic          o_busy
);

    logic [0:0]          r_state;
    logic [3:0]          r_gnt;
    logic [1:0]          r_sel;
    logic                r_we;
    logic [AW-1:0]       r_waddr;
    logic                r_mdu_hi;
    logic [1:0]          r_ptr;

    logic [3:0][AW-1:0]  w_dst;
    logic [3:0]          w_elig;
    logic [3:0]          w_win;
    logic [1:0]          w_idx;
    logic                w_any;
    logic [1:0]          w_ptr_nxt;

    assign w_dst = {i_dst3, i_dst2, i_dst1, i_dst0};

    // A source is masked while its grant is showing; during the high-half
    // cycle the MDU is masked because it still holds req.
    assign w_elig = i_req & ~(r_gnt | {r_mdu_hi, 3'b000});

    rr_arbiter4 #(.RR_EN(RR_EN)) u_arb (
        .i_elig    (w_elig),
        .i_ptr     (r_ptr),
        .o_win     (w_win),
        .o_idx     (w_idx),
        .o_any     (w_any),
        .o_ptr_nxt (w_ptr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_ARB;
            r_gnt    <= '0;
            r_sel    <= WB_SEL_ALU;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_mdu_hi <= 1'b0;
            r_ptr    <= 2'd0;
        end else begin
            case (r_state)
                ST_MDU_HI: begin
                    // High half goes out regardless of stall so the pair stays atomic.
                    r_gnt    <= '0;
                    r_sel    <= WB_SEL_MDU;
                    r_we     <= 1'b1;
                    r_waddr  <= HI_ADDR;
                    r_mdu_hi <= 1'b1;
                    r_state  <= ST_ARB;
                end
                default: begin
                    r_mdu_hi <= 1'b0;
                    if (!i_stall && w_any) begin
                        r_gnt   <= w_win;
                        r_sel   <= w_idx;
                        r_we    <= 1'b1;
                        r_waddr <= w_dst[w_idx];
                        r_ptr   <= w_ptr_nxt;
                        if (w_idx == WB_SEL_MDU)
                            r_state <= ST_MDU_HI;
                    end else begin
                        r_gnt <= '0;
                        r_we  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_gnt      = r_gnt;
    assign o_sel      = r_sel;
    assign o_rf_we    = r_we;
    assign o_rf_waddr = r_waddr;
    assign o_mdu_hi   = r_mdu_hi;
    assign o_busy     = r_mdu_hi;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Scoreboard bench: directed stimulus queues the expected writes, per-instance
// monitors pop and compare on every rf_we cycle.
module tb_wb_port_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0, req_fp = '0;
    logic [3:0] dst0 = '0, dst1 = '0, dst2 = '0, dst3 = '0;
    logic       stall = 1'b0;

    logic [3:0] rr_gnt, fp_gnt;
    logic [1:0] rr_sel, fp_sel;
    logic       rr_we, fp_we;
    logic [3:0] rr_waddr, fp_waddr;
    logic       rr_hi, fp_hi, rr_busy, fp_busy;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [3:0] waddr;
        logic       hi;
    } wr_t;

    wr_t q_rr[$];
    wr_t q_fp[$];
    int  errs = 0;
    int  chks = 0;

    always #5 clk = ~clk;

    wb_port_scheduler #(.AW(4), .RR_EN(1'b1), .HI_ADDR(4'd0)) u_rr (
        .clk(clk), .rst_n(rst_n), .i_req(req),
        .i_dst0(dst0), .i_dst1(dst1), .i_dst2(dst2), .i_dst3(dst3),
        .i_stall(stall), .o_gnt(rr_gnt), .o_sel(rr_sel), .o_rf_we(rr_we),
        .o_rf_waddr(rr_waddr), .o_mdu_hi(rr_hi), .o_busy(rr_busy)
    );

    wb_port_scheduler #(.AW(4), .RR_EN(1'b0), .HI_ADDR(4'd0)) u_fp (
        .clk(clk), .rst_n(rst_n), .i_req(req_fp),
        .i_dst0(dst0), .i_dst1(dst1), .i_dst2(dst2), .i_dst3(dst3),
        .i_stall(stall), .o_gnt(fp_gnt), .o_sel(fp_sel), .o_rf_we(fp_we),
        .o_rf_waddr(fp_waddr), .o_mdu_hi(fp_hi), .o_busy(fp_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic wr_t wr(input logic [3:0] g, input logic [1:0] s,
                               input logic [3:0] a, input logic h);
        wr_t e;
        e.gnt = g; e.sel = s; e.waddr = a; e.hi = h;
        return e;
    endfunction

    // Monitors: every write must match the head of its queue; idle cycles
    // must show no grant and no high-half flag.
    always @(negedge clk) begin
        wr_t e;
        if (rr_we === 1'b1) begin
            if (q_rr.size() == 0) begin
                chks++; errs++;
                $display("FAIL rr_unexpected_write: got waddr=%0d sel=%0d expected no write at %0t",
                         rr_waddr, rr_sel, $time);
            end else begin
                e = q_rr.pop_front();
                chk("rr_write", {21'd0, rr_gnt, rr_sel, rr_waddr, rr_hi}, {21'd0, e});
                chk("rr_busy", {31'd0, rr_busy}, {31'd0, e.hi});
            end
        end else begin
            chk("rr_idle", {29'd0, rr_gnt[2:0] | {2'b0, rr_hi}, rr_busy}, 32'd0);
            chk("rr_idle_gnt3", {31'd0, rr_gnt[3]}, 32'd0);
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (fp_we === 1'b1) begin
            if (q_fp.size() == 0) begin
                chks++; errs++;
                $display("FAIL fp_unexpected_write: got waddr=%0d sel=%0d expected no write at %0t",
                         fp_waddr, fp_sel, $time);
            end else begin
                e = q_fp.pop_front();
                chk("fp_write", {21'd0, fp_gnt, fp_sel, fp_waddr, fp_hi}, {21'd0, e});
                chk("fp_busy", {31'd0, fp_busy}, {31'd0, e.hi});
            end
        end else begin
            chk("fp_idle", {27'd0, fp_gnt, fp_hi}, 32'd0);
        end
    end

    initial begin
        repeat (2) cyc();
        chk("rst_gnt", {28'd0, rr_gnt}, 32'd0);
        chk("rst_sel", {30'd0, rr_sel}, 32'd0);
        chk("rst_we", {31'd0, rr_we}, 32'd0);
        chk("rst_waddr", {28'd0, rr_waddr}, 32'd0);
        chk("rst_hi_busy", {30'd0, rr_hi, rr_busy}, 32'd0);
        chk("rst_fp", {22'd0, fp_gnt, fp_sel, fp_we, fp_waddr, fp_hi}, 32'd0);

        // Round robin, all four requesting; each requester drops after its grant
        rst_n = 1'b1;
        dst0 = 4'd1; dst1 = 4'd2; dst2 = 4'd3; dst3 = 4'd7;
        q_rr.push_back(wr(4'b0001, 2'd0, 4'd1, 1'b0));
        q_rr.push_back(wr(4'b0010, 2'd1, 4'd2, 1'b0));
        q_rr.push_back(wr(4'b0100, 2'd2, 4'd3, 1'b0));
        q_rr.push_back(wr(4'b1000, 2'd3, 4'd7, 1'b0));
        q_rr.push_back(wr(4'b0000, 2'd3, 4'd0, 1'b1));
        q_rr.push_back(wr(4'b0001, 2'd0, 4'd1, 1'b0));
        req = 4'b1111;
        cyc();
        cyc(); req = 4'b1110;
        cyc(); req = 4'b1101;
        cyc(); req = 4'b1011;
        cyc(); req = 4'b1111;
        cyc(); req = 4'b0001;
        cyc(); req = 4'b0000;
        repeat (2) cyc();

        // Single ALU write, then no write once the grant cycle ends
        dst0 = 4'd5;
        q_rr.push_back(wr(4'b0001, 2'd0, 4'd5, 1'b0));
        req = 4'b0001;
        cyc();
        cyc(); req = 4'b0000;
        chk("alu_drop_we", {31'd0, rr_we}, 32'd0);
        cyc();

        // Stall holds off a pending LINK request for three cycles
        req = 4'b0100; stall = 1'b1;
        cyc(); chk("stall_we1", {31'd0, rr_we}, 32'd0);
        cyc(); chk("stall_we2", {31'd0, rr_we}, 32'd0);
        cyc(); chk("stall_we3", {31'd0, rr_we}, 32'd0);
        stall = 1'b0;
        q_rr.push_back(wr(4'b0100, 2'd2, 4'd3, 1'b0));
        cyc();
        cyc(); req = 4'b0000;
        cyc();

        // Stall rising during the MDU low half does not suppress the high half
        dst3 = 4'd9;
        q_rr.push_back(wr(4'b1000, 2'd3, 4'd9, 1'b0));
        q_rr.push_back(wr(4'b0000, 2'd3, 4'd0, 1'b1));
        req = 4'b1000;
        cyc(); stall = 1'b1;
        cyc();
        cyc(); req = 4'b0000; stall = 1'b0;
        cyc();

        // Reset in the middle of an MDU pair aborts the high half
        dst3 = 4'd6;
        q_rr.push_back(wr(4'b1000, 2'd3, 4'd6, 1'b0));
        req = 4'b1000;
        cyc();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_gnt", {28'd0, rr_gnt}, 32'd0);
        chk("midrst_sel", {30'd0, rr_sel}, 32'd0);
        chk("midrst_we", {31'd0, rr_we}, 32'd0);
        chk("midrst_waddr", {28'd0, rr_waddr}, 32'd0);
        chk("midrst_hi_busy", {30'd0, rr_hi, rr_busy}, 32'd0);
        req = 4'b0000;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();

        // Fixed priority: LOAD before LINK, ALU arriving late is served next
        dst0 = 4'd4; dst1 = 4'd2; dst2 = 4'd3;
        q_fp.push_back(wr(4'b0010, 2'd1, 4'd2, 1'b0));
        q_fp.push_back(wr(4'b0100, 2'd2, 4'd3, 1'b0));
        q_fp.push_back(wr(4'b0001, 2'd0, 4'd4, 1'b0));
        req_fp = 4'b0110;
        cyc();
        cyc(); req_fp = 4'b0101;
        cyc(); req_fp = 4'b0001;
        cyc(); req_fp = 4'b0000;
        repeat (3) cyc();

        chk("rr_queue_drained", q_rr.size(), 32'd0);
        chk("fp_queue_drained", q_fp.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
